// File: rtl/alu_cdb_pkg.sv
// Shared widths and constants for the ALU common-data-bus / writeback stage.
// Kept consistent with the ALU's tagWidth, dataWidth, aluRSWidth and tagFree.
package alu_cdb_pkg;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int RS_W   = 3;
  localparam logic [TAG_W-1:0] TAG_FREE = '0;

endpackage

// File: rtl/wb_fifo.sv
// Writeback FIFO for the register-file port; exposes its entries and
// per-entry valid bits so the top level can run the tag-lookup CAM.
module wb_fifo #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic                             pop,
  input  logic [TAG_W-1:0]                 push_tag,
  input  logic [DATA_W-1:0]                push_data,
  output logic [TAG_W-1:0]                 head_tag,
  output logic [DATA_W-1:0]                head_data,
  output logic                             empty,
  output logic                             full,
  output logic [$clog2(DEPTH):0]           count,
  output logic [DEPTH-1:0][TAG_W-1:0]      ent_tag,
  output logic [DEPTH-1:0][DATA_W-1:0]     ent_data,
  output logic [DEPTH-1:0]                 ent_valid
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] rd_ptr;
  logic [AW:0] wr_ptr;
  logic        wr_en;

  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  // At full, a same-cycle pop frees the head slot that the tail is about to overwrite.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (wr_en) begin
        ent_tag[wr_ptr[AW-1:0]]  <= push_tag;
        ent_data[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr                   <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_valid
    assign ent_valid[i] = ({1'b0, AW'(i) - rd_ptr[AW-1:0]} < count);
  end

  assign head_tag  = empty ? '0 : ent_tag[rd_ptr[AW-1:0]];
  assign head_data = empty ? '0 : ent_data[rd_ptr[AW-1:0]];

endmodule

// File: rtl/alu_cdb.sv
// ALU common-data-bus broadcast, RF writeback queue (LSBuf has priority)
// and decoder tag lookup over in-flight results.
module alu_cdb
  import alu_cdb_pkg::*;
#(
  parameter int               DATA_W   = alu_cdb_pkg::DATA_W,
  parameter int               TAG_W    = alu_cdb_pkg::TAG_W,
  parameter int               RS_W     = alu_cdb_pkg::RS_W,
  parameter int               DEPTH    = 4,
  parameter logic [TAG_W-1:0] TAG_FREE = alu_cdb_pkg::TAG_FREE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [RS_W-1:0]   alu_rs_num,
  input  logic [TAG_W-1:0]  alu_tag,
  input  logic [DATA_W-1:0] alu_data,
  output logic              cdb_valid,
  output logic [RS_W-1:0]   cdb_rs_num,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  input  logic              lsb_wb_valid,
  output logic              rf_we,
  output logic [TAG_W-1:0]  rf_tag,
  output logic [DATA_W-1:0] rf_data,
  input  logic [TAG_W-1:0]  q1_tag,
  input  logic [TAG_W-1:0]  q2_tag,
  output logic              q1_hit,
  output logic              q2_hit,
  output logic [DATA_W-1:0] q1_data,
  output logic [DATA_W-1:0] q2_data,
  output logic              fifo_full,
  output logic              overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                         push_req;
  logic                         empty;
  logic                         full;
  logic [CW-1:0]                count;
  logic [DEPTH-1:0][TAG_W-1:0]  ent_tag;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;
  logic [DEPTH-1:0]             ent_valid;

  assign cdb_valid  = alu_valid;
  assign cdb_rs_num = alu_valid ? alu_rs_num : '0;
  assign cdb_tag    = alu_valid ? alu_tag    : TAG_FREE;
  assign cdb_data   = alu_valid ? alu_data   : '0;

  assign push_req = alu_valid && (alu_tag != TAG_FREE);
  assign rf_we    = !empty && !lsb_wb_valid;

  wb_fifo #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .pop       (rf_we),
    .push_tag  (alu_tag),
    .push_data (alu_data),
    .head_tag  (rf_tag),
    .head_data (rf_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .ent_tag   (ent_tag),
    .ent_data  (ent_data),
    .ent_valid (ent_valid)
  );

  // One cycle early so issue logic can stop before the last slot is taken.
  assign fifo_full = full || ((count == CW'(DEPTH - 1)) && alu_valid);

  always_ff @(posedge clk) begin
    if (rst)                               overflow <= 1'b0;
    else if (push_req && full && !rf_we)   overflow <= 1'b1;
  end

  // Tags in flight are unique; the live ALU input overrides any queued match.
  always_comb begin
    q1_hit  = 1'b0;
    q1_data = '0;
    q2_hit  = 1'b0;
    q2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && ent_tag[i] == q1_tag) begin
        q1_hit  = 1'b1;
        q1_data = ent_data[i];
      end
      if (ent_valid[i] && ent_tag[i] == q2_tag) begin
        q2_hit  = 1'b1;
        q2_data = ent_data[i];
      end
    end
    if (alu_valid && alu_tag == q1_tag) begin
      q1_hit  = 1'b1;
      q1_data = alu_data;
    end
    if (alu_valid && alu_tag == q2_tag) begin
      q2_hit  = 1'b1;
      q2_data = alu_data;
    end
    if (q1_tag == TAG_FREE) begin
      q1_hit  = 1'b0;
      q1_data = '0;
    end
    if (q2_tag == TAG_FREE) begin
      q2_hit  = 1'b0;
      q2_data = '0;
    end
  end

endmodule

// File: tb/tb_alu_cdb.sv
// Randomized plus directed bench for alu_cdb with a queue-based reference
// model and a scoreboard monitor on the RF write port.
module tb_alu_cdb;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [2:0]  alu_rs_num;
  logic [3:0]  alu_tag;
  logic [31:0] alu_data;
  logic        cdb_valid;
  logic [2:0]  cdb_rs_num;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        lsb_wb_valid;
  logic        rf_we;
  logic [3:0]  rf_tag;
  logic [31:0] rf_data;
  logic [3:0]  q1_tag, q2_tag;
  logic        q1_hit, q2_hit;
  logic [31:0] q1_data, q2_data;
  logic        fifo_full;
  logic        overflow;

  alu_cdb #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_rs_num   (alu_rs_num),
    .alu_tag      (alu_tag),
    .alu_data     (alu_data),
    .cdb_valid    (cdb_valid),
    .cdb_rs_num   (cdb_rs_num),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .lsb_wb_valid (lsb_wb_valid),
    .rf_we        (rf_we),
    .rf_tag       (rf_tag),
    .rf_data      (rf_data),
    .q1_tag       (q1_tag),
    .q2_tag       (q2_tag),
    .q1_hit       (q1_hit),
    .q2_hit       (q2_hit),
    .q1_data      (q1_data),
    .q2_data      (q2_data),
    .fifo_full    (fifo_full),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] data;
  } ent_t;

  ent_t mq[$];     // reference FIFO contents
  ent_t sb_q[$];   // expected RF write stream
  logic ref_ovf;
  int   n_checks;
  int   n_fail;
  logic init_done;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] ref_lookup(input logic [3:0] q, input logic v,
                                             input logic [3:0] t, input logic [31:0] d);
    if (q == 4'd0) return '0;
    if (v && t == q) return {1'b1, d};
    foreach (mq[i]) if (mq[i].tag == q) return {1'b1, mq[i].data};
    return '0;
  endfunction

  function automatic logic [3:0] fresh_tag();
    logic [3:0] t;
    logic used;
    forever begin
      t = 4'($urandom_range(1, 15));
      used = 1'b0;
      foreach (mq[i]) if (mq[i].tag == t) used = 1'b1;
      if (!used) return t;
    end
  endfunction

  task automatic step(input logic r, input logic v, input logic [2:0] rs, input logic [3:0] tg,
                      input logic [31:0] d, input logic l, input logic [3:0] qa, input logic [3:0] qb);
    logic [32:0] e1, e2;
    logic        pop, push;
    ent_t        ne;
    rst = r; alu_valid = v; alu_rs_num = rs; alu_tag = tg; alu_data = d;
    lsb_wb_valid = l; q1_tag = qa; q2_tag = qb;
    @(negedge clk);
    chk("cdb_valid", 64'(cdb_valid), 64'(v));
    chk("cdb_rs_num", 64'(cdb_rs_num), v ? 64'(rs) : 64'd0);
    chk("cdb_tag", 64'(cdb_tag), v ? 64'(tg) : 64'd0);
    chk("cdb_data", 64'(cdb_data), v ? 64'(d) : 64'd0);
    chk("rf_we", 64'(rf_we), 64'(mq.size() > 0 && !l));
    chk("rf_tag", 64'(rf_tag), mq.size() > 0 ? 64'(mq[0].tag) : 64'd0);
    chk("rf_data", 64'(rf_data), mq.size() > 0 ? 64'(mq[0].data) : 64'd0);
    chk("fifo_full", 64'(fifo_full), 64'(mq.size() == DEPTH || (mq.size() == DEPTH - 1 && v)));
    chk("overflow", 64'(overflow), 64'(ref_ovf));
    e1 = ref_lookup(qa, v, tg, d);
    e2 = ref_lookup(qb, v, tg, d);
    chk("q1_hit", 64'(q1_hit), 64'(e1[32]));
    chk("q1_data", 64'(q1_data), 64'(e1[31:0]));
    chk("q2_hit", 64'(q2_hit), 64'(e2[32]));
    chk("q2_data", 64'(q2_data), 64'(e2[31:0]));
    @(posedge clk);
    if (r) begin
      mq.delete();
      sb_q.delete();
      ref_ovf = 1'b0;
    end else begin
      pop  = (mq.size() > 0) && !l;
      push = v && (tg != 4'd0);
      if (push && mq.size() == DEPTH && !pop) begin
        ref_ovf = 1'b1;
      end else begin
        if (pop) void'(mq.pop_front());
        if (push) begin
          ne.tag = tg;
          ne.data = d;
          mq.push_back(ne);
          sb_q.push_back(ne);
        end
      end
    end
    #1;
  endtask

  task automatic idle(input logic l);
    step(1'b0, 1'b0, 3'd0, 4'd0, 32'd0, l, 4'd0, 4'd0);
  endtask

  task automatic push1(input logic [3:0] tg, input logic [31:0] d, input logic l);
    step(1'b0, 1'b1, 3'($urandom_range(0, 7)), tg, d, l, tg, 4'd0);
  endtask

  // Scoreboard monitor: every RF write must match the next expected result.
  always @(negedge clk) begin
    ent_t e;
    if (init_done && rf_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("rf_unexpected_write", 64'(rf_tag), 64'd0);
        if (rf_tag == 4'd0) chk("rf_unexpected_we", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_rf_tag", 64'(rf_tag), 64'(e.tag));
        chk("sb_rf_data", 64'(rf_data), 64'(e.data));
      end
    end
  end

  initial begin
    int lsb_pct;
    logic [3:0] tg, qa, qb;
    logic v;
    n_checks = 0; n_fail = 0; ref_ovf = 1'b0; init_done = 1'b0;
    rst = 1'b1; alu_valid = 1'b0; alu_rs_num = '0; alu_tag = '0; alu_data = '0;
    lsb_wb_valid = 1'b0; q1_tag = '0; q2_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    init_done = 1'b1;
    idle(1'b0);

    // single result
    step(1'b0, 1'b1, 3'd2, 4'd3, 32'h1234, 1'b0, 4'd3, 4'd0);
    idle(1'b0);
    idle(1'b0);

    // LSBuf contention
    push1(4'd1, 32'hA1, 1'b1);
    push1(4'd2, 32'hA2, 1'b1);
    push1(4'd3, 32'hA3, 1'b1);
    step(1'b0, 1'b1, 3'd1, 4'd4, 32'hA4, 1'b1, 4'd1, 4'd4);
    repeat (6) idle(1'b0);

    // lookup: same-cycle input hit, then queued hit, TAG_FREE miss
    step(1'b0, 1'b1, 3'd5, 4'd5, 32'h55AA, 1'b1, 4'd0, 4'd5);
    step(1'b0, 1'b0, 3'd0, 4'd0, 32'd0, 1'b1, 4'd5, 4'd0);
    step(1'b0, 1'b1, 3'd0, 4'd0, 32'hFFFF, 1'b1, 4'd0, 4'd5);
    repeat (3) idle(1'b0);

    // overflow
    for (int i = 0; i < DEPTH; i++) push1(4'(i + 1), 32'h100 + 32'(i), 1'b1);
    push1(4'd12, 32'hDEAD, 1'b1);
    idle(1'b1);
    repeat (DEPTH + 2) idle(1'b0);

    // full push+pop, covering pointer wrap
    for (int i = 0; i < DEPTH; i++) push1(4'(i + 1), 32'h200 + 32'(i), 1'b1);
    for (int i = 0; i < 2 * DEPTH; i++) push1(fresh_tag(), $urandom, 1'b0);
    repeat (DEPTH + 2) idle(1'b0);

    // reset mid-drain
    for (int i = 0; i < 3; i++) push1(4'(i + 6), 32'h300 + 32'(i), 1'b1);
    step(1'b1, 1'b0, 3'd0, 4'd0, 32'd0, 1'b1, 4'd6, 4'd7);
    step(1'b0, 1'b1, 3'd3, 4'd4, 32'h444, 1'b0, 4'd6, 4'd4);
    repeat (3) idle(1'b0);

    // randomized traffic
    lsb_pct = 20;
    for (int n = 0; n < 600; n++) begin
      if (n % 50 == 0) lsb_pct = (n / 50 % 3 == 0) ? 20 : (n / 50 % 3 == 1) ? 60 : 90;
      v  = ($urandom_range(0, 3) != 0);
      tg = ($urandom_range(0, 7) == 0) ? 4'd0 : fresh_tag();
      case ($urandom_range(0, 3))
        0: qa = 4'($urandom_range(0, 15));
        1: qa = tg;
        2: qa = (mq.size() > 0) ? mq[$urandom_range(0, mq.size() - 1)].tag : 4'd0;
        default: qa = 4'd0;
      endcase
      qb = (mq.size() > 0) ? mq[$urandom_range(0, mq.size() - 1)].tag : 4'($urandom_range(0, 15));
      step(($urandom_range(0, 99) == 0), v, 3'($urandom_range(0, 7)), tg, $urandom,
           ($urandom_range(0, 99) < lsb_pct), qa, qb);
    end
    repeat (DEPTH + 2) idle(1'b0);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cdb.md
# alu_cdb

ALU common-data-bus and writeback stage, directly downstream of the ALU reservation station. It broadcasts each ALU result in the cycle it is produced, which frees the RS entry and wakes up dependent RS operands. It also queues the result in a small FIFO for the single register-file write port, where LSBuf writebacks have priority. While a result waits in the FIFO, the block answers tag lookups from the decoder so a freshly issued instruction never waits on a tag that has already been broadcast.

## Interface
Parameters:
- DATA_W, 32, result width
- TAG_W, 4, rename tag width
- RS_W, 3, ALU RS index width
- DEPTH, 4, writeback FIFO entries; power of two, ≥2
- TAG_FREE, 0, tag value meaning "no pending producer"

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alu_valid  in  1  ALU result valid this cycle
- alu_rs_num  in  RS_W  RS slot that produced the result
- alu_tag  in  TAG_W  destination tag
- alu_data  in  DATA_W  result value
- cdb_valid  out  1  broadcast valid; drives ALU aluFinish
- cdb_rs_num  out  RS_W  slot to free
- cdb_tag  out  TAG_W  broadcast tag
- cdb_data  out  DATA_W  broadcast data
- lsb_wb_valid  in  1  LSBuf owns the RF write port this cycle
- rf_we  out  1  RF write enable
- rf_tag  out  TAG_W  tag the RF matches against its pending tags
- rf_data  out  DATA_W  write data
- q1_tag, q2_tag  in  TAG_W  decoder lookup tags
- q1_hit, q2_hit  out  1  tag found among pending results
- q1_data, q2_data  out  DATA_W  matching value; 0 on miss
- fifo_full  out  1  stall issue to the ALU RS
- overflow  out  1  sticky error flag

## Operation
- Broadcast (combinational):
  - cdb_valid = alu_valid, and cdb_rs_num/tag/data equal the inputs.
  - When alu_valid=0, the broadcast outputs are 0, and cdb_tag equals TAG_FREE.
- Push: on alu_valid && alu_tag != TAG_FREE, {tag, data} is written at the tail. A TAG_FREE result is broadcast but never queued.
- Pop:
  - rf_we = !empty && !lsb_wb_valid.
  - rf_tag and rf_data always present the FIFO head, and are 0 when the FIFO is empty.
  - The head advances on the clock edge when rf_we=1.
- Pointers:
  - rd_ptr and wr_ptr are log2(DEPTH)+1 bits.
  - empty when the pointers are equal; full when the MSBs differ and the low bits are equal.
  - Wrap-around is modular.
- fifo_full = full || (count == DEPTH-1 && alu_valid). This gives issue logic one cycle of slack.
- Simultaneous push and pop are allowed at any occupancy, including full, provided rf_we=1.
- Push when full and rf_we=0: the result is dropped, the FIFO is unchanged and overflow is set. overflow stays set until rst.
- Lookup (combinational):
  - Sources are all valid FIFO entries plus the current alu input when alu_valid=1.
  - Tags in flight are unique, so at most one entry matches. If the input and an entry both match, the input wins.
  - A query with q_tag == TAG_FREE always returns a miss.
- Reset sets the pointers to 0 and clears overflow. rf_* outputs read 0 and q*_hit reads 0 from the next cycle on. Entries that were in flight are discarded.

## Timing
- Broadcast latency is 0. A result registered by the ALU at posedge N appears on cdb_* during cycle N, and the ALU clears the RS slot at negedge N.
- Writeback latency: a result pushed at the end of cycle N reaches rf_we=1 in cycle N+1 at the earliest. Each cycle with lsb_wb_valid=1 adds one cycle.
- Lookup: a result is visible on q*_hit from its broadcast cycle through the last cycle before its RF write edge. After that edge the RF holds the value.
- Throughput: one push and one pop per cycle.

## Structure
- A shared defines/package holds DATA_W, TAG_W, RS_W and TAG_FREE, consistent with the ALU's tagWidth, dataWidth, aluRSWidth and tagFree.
- Sub-module wb_fifo: parameterised FIFO exposing its entry array plus per-entry valid bits for the lookup CAM. Broadcast and lookup muxing live in the top level.

## Test plan
- Single result: alu_valid, tag 3, data 0x1234, rs 2 → same cycle cdb_valid=1, cdb_rs_num=2. Next cycle rf_we=1, rf_tag=3, rf_data=0x1234. Following cycle the FIFO is empty.
- LSBuf contention: push tags 1,2,3 on consecutive cycles with lsb_wb_valid=1 for 3 cycles → rf_we stays 0 and fifo_full asserts with count=3 and a push pending. After release, writes occur in order 1,2,3, one per cycle.
- Lookup: tag 5 queued and held by lsb_wb_valid; q1_tag=5 → q1_hit=1 with correct data. q2_tag=5 together with alu_valid tag 5 in the same cycle also hits. q1_tag=TAG_FREE → miss.
- Overflow: fill DEPTH entries, hold lsb_wb_valid, push one more → overflow=1, FIFO contents unchanged, drain order intact.
- Full push+pop: at full with lsb_wb_valid=0, push tag 9 → count stays DEPTH, head pops, and tag 9 drains last. Repeat 2·DEPTH times to cover pointer wrap.
- Reset mid-drain: 3 entries queued, rst for 1 cycle → rf_we=0, q hits 0, overflow=0. New tag 4 then writes back normally.
